// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner and the LED blinker.
// Mode encoding is agreed with the blinker; keep both sides in step.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_CYC_DEF = 1_000_000;  // 20 ms at 50 MHz
  localparam int LONG_CYC_DEF     = 50_000_000; // 1 s at 50 MHz

  localparam int MODE_1HZ = 0;
  localparam int MODE_2HZ = 1;
  localparam int MODE_4HZ = 2;
  localparam int MODE_8HZ = 3;

  // Advance a mode index with wrap-around at num_modes.
  function automatic int next_mode(input int cur, input int num_modes);
    return (cur >= num_modes - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs.
// Latency: 2 clk edges. No backpressure; samples every cycle.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_mode.sv
// Debounces a raw push-button into level/press/release/long pulses and a blink mode register.
// Latency: press/release pulse DEBOUNCE_CYC+3 edges after the input edge; long pulse LONG_CYC edges after press.
// No backpressure: pulses are single-cycle registered strobes, mode is a held level.
module btn_debounce_mode
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF,
  parameter int NUM_MODES    = 4,
  localparam int MODE_W      = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_in,
  output logic              btn_level,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              long_pulse,
  output logic [MODE_W-1:0] mode
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  logic btn_sync;

  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_fired_q, long_fired_d;
  logic              level_d, press_d, release_d, long_d;
  logic [MODE_W-1:0] mode_d;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      long_fired_q  <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      mode          <= MODE_W'(MODE_1HZ);
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_fired_q  <= long_fired_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      mode          <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = btn_level;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    mode_d       = mode;

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = PRESSED;
          level_d      = 1'b1;
          press_d      = 1'b1;
          hold_cnt_d   = '0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        // Long fire and release edge may coincide; both take effect.
        if (hold_cnt_q == HOLD_LAST && !long_fired_q) begin
          long_d       = 1'b1;
          mode_d       = MODE_W'(MODE_1HZ);
          long_fired_d = 1'b1;
        end
        if (!btn_sync) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end

      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          if (!long_fired_q) begin
            mode_d = MODE_W'(next_mode(int'(mode), NUM_MODES));
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_btn_debounce_mode.sv
// Bench for btn_debounce_mode: run-length debounce model checked every cycle, plus hand-computed pulse edges and modes.
module tb_btn_debounce_mode;
  localparam int D  = 8;
  localparam int L  = 32;
  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [1:0] mode;

  btn_debounce_mode #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .NUM_MODES(NM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .mode          (mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Model: accepted level flips once the synchronized input has disagreed with it
  // on D+1 consecutive edges; long press fires on the L-th settled-held edge.
  logic       m_s1, m_s2, m_level, m_press, m_rel, m_long, m_fired;
  logic [1:0] m_mode;
  int         m_run, m_hold;

  always @(posedge clk) begin
    logic obs;
    cyc++;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      m_fired = 0; m_mode = 0; m_run = 0; m_hold = 0;
    end else begin
      obs = m_s2; m_s2 = m_s1; m_s1 = btn_in;
      m_press = 0; m_rel = 0; m_long = 0;
      if (m_level && m_run == 0 && m_hold < L) begin
        m_hold++;
        if (m_hold == L && !m_fired) begin
          m_long = 1; m_mode = 0; m_fired = 1;
        end
      end
      if (obs != m_level) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run = 0;
        if (m_level) begin
          m_press = 1; m_hold = 0; m_fired = 0;
        end else begin
          m_rel = 1;
          if (!m_fired) m_mode = 2'((int'(m_mode) + 1) % NM);
        end
      end
    end
  end

  int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int last_press = -1, last_rel = -1, last_long = -1, mode_at_long = -1;

  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (btn_level !== m_level || press_pulse !== m_press || release_pulse !== m_rel ||
          long_pulse !== m_long || mode !== m_mode) begin
        n_bad++;
        $display("FAIL model_cmp cyc=%0d dut lvl/prs/rel/lng/mode=%b%b%b%b/%0d required=%b%b%b%b/%0d",
                 cyc, btn_level, press_pulse, release_pulse, long_pulse, mode,
                 m_level, m_press, m_rel, m_long, m_mode);
      end
    end
    if (press_pulse === 1'b1) begin press_cnt++; last_press = cyc; end
    if (release_pulse === 1'b1) begin rel_cnt++; last_rel = cyc; end
    if (long_pulse === 1'b1) begin long_cnt++; last_long = cyc; mode_at_long = int'(mode); end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check(name, int'({btn_level, press_pulse, release_pulse, long_pulse, mode}), 0);
  endtask

  // Short press: returns edge numbers of the first 1-sample and first 0-sample.
  task automatic short_press(input int hold, output int st, output int rl);
    btn_in = 1'b1; st = cyc + 1;
    tick(hold);
    btn_in = 1'b0; rl = cyc + 1;
    tick(20);
  endtask

  initial begin
    int st, rl, pc, rc;
    rst_n = 1'b0; btn_in = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;

    // 1. reset with toggling input
    for (int i = 0; i < 3; i++) begin
      btn_in = i[0];
      @(negedge clk);
      check_zero("reset_outputs");
    end
    rst_n = 1'b1; btn_in = 1'b0;
    tick(3);

    // 2. clean short press
    pc = press_cnt; rc = rel_cnt;
    short_press(20, st, rl);
    check("t2_press_edge", last_press, st + 10);
    check("t2_release_edge", last_rel, rl + 10);
    check("t2_press_count", press_cnt - pc, 1);
    check("t2_release_count", rel_cnt - rc, 1);
    check("t2_mode", int'(mode), 1);
    check("t2_no_long", long_cnt, 0);

    // 3. bounce rejection then a real press
    pc = press_cnt;
    for (int i = 0; i < 4; i++) begin
      btn_in = 1'b1; tick(5);
      btn_in = 1'b0; tick(3);
    end
    tick(12);
    check("t3_no_press", press_cnt - pc, 0);
    check("t3_level", int'(btn_level), 0);
    check("t3_mode_held", int'(mode), 1);
    short_press(20, st, rl);
    check("t3_one_press", press_cnt - pc, 1);
    check("t3_press_edge", last_press, st + 10);
    check("t3_mode", int'(mode), 2);

    // 4. wrap-around from mode 0
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    check("t4_mode_reset", int'(mode), 0);
    for (int i = 1; i <= 4; i++) begin
      short_press(12, st, rl);
      check("t4_mode_seq", int'(mode), i % NM);
    end

    // 5. long press from mode 2
    short_press(12, st, rl);
    short_press(12, st, rl);
    check("t5_mode_start", int'(mode), 2);
    rc = rel_cnt;
    short_press(60, st, rl);
    check("t5_press_edge", last_press, st + 10);
    check("t5_long_edge", last_long, st + 42);
    check("t5_mode_at_long", mode_at_long, 0);
    check("t5_long_count", long_cnt, 1);
    check("t5_release_edge", last_rel, rl + 10);
    check("t5_release_count", rel_cnt - rc, 1);
    check("t5_mode_after", int'(mode), 0);

    // 6. reset mid-press with button held
    btn_in = 1'b1; tick(15);
    check("t6_held_level", int'(btn_level), 1);
    rst_n = 1'b0; tick(1);
    check_zero("t6_reset_outputs");
    rst_n = 1'b1; st = cyc + 1;
    tick(20);
    check("t6_fresh_press", last_press, st + 10);
    check("t6_mode", int'(mode), 0);
    btn_in = 1'b0; rl = cyc + 1;
    tick(20);
    check("t6_release_edge", last_rel, rl + 10);
    check("t6_mode_after", int'(mode), 1);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_mode.md
Name: btn_debounce_mode

Overview:
- Upstream stage for the LED blinker. Conditions a raw, bouncy push-button from the board.
- Produces debounced level and event pulses.
- Maintains a mode register that the blinker uses to select its blink rate: mode 0 = 1 Hz, higher modes = faster rates.
- Short press advances the mode with wrap-around. Long press forces mode 0.

Parameters:
- DEBOUNCE_CYC, 1_000_000: cycles the synchronized input must stay stable to accept an edge (20 ms at 50 MHz); minimum 2.
- LONG_CYC, 50_000_000: cycles held in PRESSED before a long press fires (1 s at 50 MHz); minimum 2.
- NUM_MODES, 4: number of blink modes; minimum 2.
- MODE_W (localparam), $clog2(NUM_MODES): mode width.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  synchronous active-low reset
- btn_in  in  1  raw button, asynchronous, active-high
- btn_level  out  1  debounced button level
- press_pulse  out  1  one-cycle pulse on accepted press
- release_pulse  out  1  one-cycle pulse on accepted release
- long_pulse  out  1  one-cycle pulse when hold reaches LONG_CYC
- mode  out  MODE_W  current blink mode, to the blinker

Behaviour:
- Clock and reset:
  - Single clock domain, rising edge.
  - All state updates only on posedge clk.
  - rst_n=0 at a clock edge clears: the synchronizer flops, state=IDLE, both counters, long_fired, and all outputs (btn_level=0, pulses=0, mode=0).
  - Reset mid-press discards the press. If the button is still held after reset, it is re-debounced from scratch and a fresh press_pulse is produced.
- Synchronizer:
  - Two-flop synchronizer: btn_sync = btn_in delayed 2 edges.
  - The FSM only ever uses btn_sync.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if btn_sync=1, go to PRESS_WAIT with db_cnt=0.
  - PRESS_WAIT:
    - btn_sync=0: return to IDLE; no outputs (bounce rejected).
    - Otherwise db_cnt++.
    - When db_cnt==DEBOUNCE_CYC-1 with btn_sync=1: go to PRESSED, btn_level<=1, press_pulse<=1, hold_cnt<=0, long_fired<=0.
  - PRESSED:
    - hold_cnt++ every cycle, saturating at LONG_CYC-1.
    - When hold_cnt==LONG_CYC-1 and long_fired=0: long_pulse<=1, mode<=0, long_fired<=1.
    - btn_sync=0: go to RELEASE_WAIT, db_cnt=0.
    - If the release edge and the long-press fire occur in the same cycle, both take effect.
  - RELEASE_WAIT:
    - btn_sync=1: return to PRESSED. hold_cnt and long_fired are preserved; no pulse.
    - Otherwise db_cnt++.
    - At db_cnt==DEBOUNCE_CYC-1: go to IDLE, btn_level<=0, release_pulse<=1.
    - On that same cycle, if long_fired=0, mode<=(mode==NUM_MODES-1)?0:mode+1.
- Latency:
  - press_pulse is registered at the (DEBOUNCE_CYC+3)th rising edge, counting the first edge that samples btn_in=1 (2 sync + 1 FSM entry + DEBOUNCE_CYC).
  - release_pulse follows the same latency, measured from the first edge that samples btn_in=0.
  - long_pulse is registered LONG_CYC edges after press_pulse.
- Pulse and mode rules:
  - All pulses are registered, exactly one cycle wide, and never overlap each other.
  - mode changes only on a short-press release or a long-press fire. It is held constant otherwise.
- Counter widths: each counter is sized with $clog2 of its limit. No counter wraps.

Decomposition:
- Shared package btn_pkg holds:
  - the FSM state enum (2 bits),
  - default constants DEBOUNCE_CYC_DEF and LONG_CYC_DEF,
  - the mode encoding constants MODE_1HZ=0 … agreed with the blinker.
- One sub-module: sync_2ff. It is a generic 2-flop synchronizer with synchronous active-low reset, reusable for other board inputs.

Test Plan:
(Bench parameters: DEBOUNCE_CYC=8, LONG_CYC=32, NUM_MODES=4.)
1. Reset: hold rst_n=0 for 3 cycles with btn_in toggling -> all outputs 0 and mode=0 throughout.
2. Clean short press: btn_in=1 for 20 cycles, then 0 -> press_pulse high at the 11th edge; release_pulse 11 edges after the release sample; mode 0->1; long_pulse never asserts.
3. Bounce rejection: btn_in glitches 1 for 5 cycles, then 0 for 3 cycles, repeated 4 times -> no pulses, btn_level=0, mode unchanged. Then hold 1 -> exactly one press_pulse.
4. Wrap-around: 4 clean short presses starting from mode=0 -> mode sequence 1,2,3,0.
5. Long press: starting at mode=2, hold btn_in=1 for 60 cycles -> press_pulse at edge 11, long_pulse at edge 43, mode=0 at that edge; release gives release_pulse with mode staying 0 (no advance).
6. Reset mid-press: assert rst_n=0 for 1 cycle while in PRESSED with btn_in still 1 -> outputs clear; fresh press_pulse 11 edges after reset release; mode=0.
